// File: rtl/jelly_stream_width_split.sv
// ---------------------------------------------------------------------------
// jelly_stream_width_split
//   Single-clock stream downsizer. Each S_NUM-unit input word is emitted as
//   RATIO = S_NUM/M_NUM consecutive M_NUM-unit output beats. The beat order
//   is chosen per word by the endian input, which is captured when the word
//   is loaded. There is no internal FIFO: one holding word plus an optional
//   one-entry input stage.
//
// Ports
//   reset    in   synchronous, active-high
//   s_clk    in   clock for all logic
//   endian   in   0: lowest beat first, 1: highest beat first (latched per word)
//   s_data   in   input word  [S_DATA_WIDTH]
//   s_valid  in   input valid
//   s_ready  out  input ready
//   m_data   out  output beat [M_DATA_WIDTH]
//   m_valid  out  output valid
//   m_ready  in   output ready
//   m_last   out  final beat of the current word (qualified by m_valid)
// ---------------------------------------------------------------------------
module jelly_stream_width_split #(
  parameter int UNIT_WIDTH   = 8,
  parameter int S_NUM        = 8,
  parameter int M_NUM        = 4,
  parameter int S_REGS       = 1,
  parameter int S_DATA_WIDTH = UNIT_WIDTH * S_NUM,
  parameter int M_DATA_WIDTH = UNIT_WIDTH * M_NUM
) (
  input  logic                    reset,
  input  logic                    s_clk,
  input  logic                    endian,
  input  logic [S_DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [M_DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last
);

  localparam int RATIO = S_NUM / M_NUM;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (S_NUM % M_NUM != 0) begin : g_param_check
    $error("jelly_stream_width_split: S_NUM must be a multiple of M_NUM");
  end

  logic [S_DATA_WIDTH-1:0] buf_data;
  logic                    buf_endian;
  logic                    buf_valid;
  logic [CNT_W-1:0]        count;

  logic                    last_beat;
  logic                    rdy_int;
  logic [CNT_W-1:0]        idx;

  // word presented to the holding buffer (either the skid stage or the port)
  logic                    up_valid;
  logic [S_DATA_WIDTH-1:0] up_data;
  logic                    up_endian;

  assign last_beat = (count == CNT_W'(RATIO - 1));
  // the buffer can take a new word when empty, or in the same cycle its
  // final beat leaves, which keeps words back-to-back without a bubble
  assign rdy_int   = !buf_valid || (m_ready && last_beat);

  // ---- input stage -------------------------------------------------------
  if (S_REGS != 0) begin : g_skid
    logic                    skid_valid;
    logic [S_DATA_WIDTH-1:0] skid_data;
    logic                    skid_endian;
    logic                    s_ready_r;
    logic                    skid_take;
    logic                    skid_keep;

    assign skid_take = s_valid && s_ready_r;
    assign skid_keep = skid_valid && !rdy_int;

    always_ff @(posedge s_clk) begin
      if (reset) begin
        skid_valid <= 1'b0;
        s_ready_r  <= 1'b0;
      end else begin
        skid_valid <= skid_take || skid_keep;
        // ready for the next cycle only if the stage will be empty then, so
        // an accepted word is never lost while downstream stalls
        s_ready_r  <= !(skid_take || skid_keep);
      end
    end

    always_ff @(posedge s_clk) begin
      if (skid_take) begin
        skid_data   <= s_data;
        skid_endian <= endian;
      end
    end

    assign up_valid  = skid_valid;
    assign up_data   = skid_data;
    assign up_endian = skid_endian;
    assign s_ready   = s_ready_r;
  end else begin : g_direct
    assign up_valid  = s_valid;
    assign up_data   = s_data;
    assign up_endian = endian;
    assign s_ready   = rdy_int && !reset;
  end

  // ---- holding buffer / beat counter -------------------------------------
  always_ff @(posedge s_clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      count     <= '0;
    end else if (buf_valid && m_ready && !last_beat) begin
      count     <= count + 1'b1;
    end else if (rdy_int) begin
      buf_valid <= up_valid;
      count     <= '0;
    end
  end

  always_ff @(posedge s_clk) begin
    if (rdy_int && up_valid) begin
      buf_data   <= up_data;
      buf_endian <= up_endian;
    end
  end

  // ---- output select -----------------------------------------------------
  assign idx     = buf_endian ? (CNT_W'(RATIO - 1) - count) : count;
  assign m_data  = buf_data[idx*M_DATA_WIDTH +: M_DATA_WIDTH];
  assign m_valid = buf_valid;
  assign m_last  = buf_valid && last_beat;

endmodule

// File: tb/tb_jelly_stream_width_split.sv
// ---------------------------------------------------------------------------
// tb_jelly_stream_width_split
//   Four instances: u0 8->4 direct, u1 8->4 skid, u2 4->4 skid (pass-through),
//   u3 8->2 direct. Directed cases on u0, throughput on u0/u1, then random
//   traffic on all four against a queue-based word model.
// ---------------------------------------------------------------------------
module tb_jelly_stream_width_split;

  localparam int NI = 4;
  localparam int RAT [NI] = '{2, 2, 1, 4};
  localparam int MW  [NI] = '{32, 32, 32, 16};
  localparam int SW  [NI] = '{64, 64, 32, 64};

  logic s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  logic        reset;
  logic        endian  [NI];
  logic        s_valid [NI];
  logic        s_ready [NI];
  logic        m_valid [NI];
  logic        m_ready [NI];
  logic        m_last  [NI];
  logic [63:0] s_data  [NI];
  logic [31:0] m_data0, m_data1, m_data2;
  logic [15:0] m_data3;

  jelly_stream_width_split #(.UNIT_WIDTH(8), .S_NUM(8), .M_NUM(4), .S_REGS(0)) u0 (
    .reset(reset), .s_clk(s_clk), .endian(endian[0]), .s_data(s_data[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .m_data(m_data0),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_last(m_last[0]));

  jelly_stream_width_split #(.UNIT_WIDTH(8), .S_NUM(8), .M_NUM(4), .S_REGS(1)) u1 (
    .reset(reset), .s_clk(s_clk), .endian(endian[1]), .s_data(s_data[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .m_data(m_data1),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_last(m_last[1]));

  jelly_stream_width_split #(.UNIT_WIDTH(8), .S_NUM(4), .M_NUM(4), .S_REGS(1)) u2 (
    .reset(reset), .s_clk(s_clk), .endian(endian[2]), .s_data(s_data[2][31:0]),
    .s_valid(s_valid[2]), .s_ready(s_ready[2]), .m_data(m_data2),
    .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_last(m_last[2]));

  jelly_stream_width_split #(.UNIT_WIDTH(8), .S_NUM(8), .M_NUM(2), .S_REGS(0)) u3 (
    .reset(reset), .s_clk(s_clk), .endian(endian[3]), .s_data(s_data[3]),
    .s_valid(s_valid[3]), .s_ready(s_ready[3]), .m_data(m_data3),
    .m_valid(m_valid[3]), .m_ready(m_ready[3]), .m_last(m_last[3]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdat(input int i);
    case (i)
      0:       return m_data0;
      1:       return m_data1;
      2:       return m_data2;
      default: return {16'h0, m_data3};
    endcase
  endfunction

  function automatic logic [63:0] wmask(input int i);
    logic [63:0] m;
    m = '1;
    if (SW[i] < 64) m = (64'd1 << SW[i]) - 64'd1;
    return m;
  endfunction

  // word model: accepted words with the endian seen at acceptance
  typedef struct { logic [63:0] w; logic e; } ent_t;
  ent_t        sbq [NI][$];
  int          beat_k [NI];
  logic [63:0] asm_w  [NI];
  logic        pend   [NI];
  logic [63:0] cur_w  [NI];
  int          left   [NI];
  int          vp     [NI];
  int          rp     [NI];
  logic        stall  [NI];
  logic [31:0] st_data[NI];
  logic        st_last[NI];
  int          first_beat[NI];
  int          last_cyc  [NI];
  int          nbeats    [NI];
  int          cyc;

  task automatic sb_reset();
    for (int i = 0; i < NI; i++) begin
      sbq[i].delete();
      beat_k[i] = 0; asm_w[i] = '0; pend[i] = 1'b0; stall[i] = 1'b0;
      left[i] = 0; vp[i] = 0; rp[i] = 0;
      first_beat[i] = -1; last_cyc[i] = -1; nbeats[i] = 0;
    end
    cyc = 0;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NI; i++) begin
      s_valid[i] = 1'b0; m_ready[i] = 1'b0; endian[i] = 1'b0; s_data[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge s_clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge s_clk);
    reset = 1'b0;
    sb_reset();
  endtask

  task automatic drive_all();
    for (int i = 0; i < NI; i++) begin
      if (!pend[i] && left[i] > 0 && ($urandom % 100) < vp[i]) begin
        pend[i]  = 1'b1;
        cur_w[i] = {$urandom, $urandom} & wmask(i);
        left[i]--;
      end
      s_valid[i] = pend[i];
      s_data[i]  = pend[i] ? cur_w[i] : {$urandom, $urandom};
      endian[i]  = 1'($urandom);
      m_ready[i] = (($urandom % 100) < rp[i]);
    end
  endtask

  task automatic take_beat(input int i);
    int   k, pos;
    ent_t ent;
    nbeats[i]++;
    if (first_beat[i] < 0) first_beat[i] = cyc;
    last_cyc[i] = cyc;
    chk($sformatf("beat_has_word%0d", i), 64'(sbq[i].size() != 0), 64'd1);
    if (sbq[i].size() == 0) return;
    ent = sbq[i][0];
    k   = beat_k[i];
    pos = ent.e ? (RAT[i] - 1 - k) : k;
    asm_w[i] = asm_w[i] | (64'(mdat(i)) << (pos * MW[i]));
    chk($sformatf("last%0d", i), 64'(m_last[i]), 64'(k == RAT[i] - 1));
    if (k == RAT[i] - 1) begin
      chk($sformatf("word%0d", i), asm_w[i], ent.w);
      void'(sbq[i].pop_front());
      asm_w[i]  = '0;
      beat_k[i] = 0;
    end else begin
      beat_k[i] = k + 1;
    end
  endtask

  task automatic sample_all();
    for (int i = 0; i < NI; i++) begin
      if (stall[i]) begin
        chk($sformatf("hold_valid%0d", i), 64'(m_valid[i]), 64'd1);
        chk($sformatf("hold_data%0d", i), 64'(mdat(i)), 64'(st_data[i]));
        chk($sformatf("hold_last%0d", i), 64'(m_last[i]), 64'(st_last[i]));
      end
      if (s_valid[i] && s_ready[i]) begin
        sbq[i].push_back('{cur_w[i], endian[i]});
        pend[i] = 1'b0;
      end
      if (m_valid[i] && m_ready[i]) take_beat(i);
      stall[i]   = m_valid[i] && !m_ready[i];
      st_data[i] = mdat(i);
      st_last[i] = m_last[i];
    end
  endtask

  task automatic step();
    @(negedge s_clk);
    drive_all();
    #1;
    sample_all();
    cyc++;
  endtask

  function automatic int outstanding();
    int n;
    n = 0;
    for (int i = 0; i < NI; i++) n += left[i] + int'(pend[i]) + sbq[i].size();
    return n;
  endfunction

  initial begin
    reset = 1'b1;
    idle_inputs();
    sb_reset();

    // reset held: nothing valid, nothing ready
    repeat (10) begin
      @(negedge s_clk);
      chk("rst_mvalid0", 64'(m_valid[0]), 64'd0);
      chk("rst_sready0", 64'(s_ready[0]), 64'd0);
      chk("rst_sready1", 64'(s_ready[1]), 64'd0);
      chk("rst_mlast3",  64'(m_last[3]),  64'd0);
    end
    reset = 1'b0;
    @(negedge s_clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rel_sready%0d", i), 64'(s_ready[i]), 64'd1);
      chk($sformatf("rel_mvalid%0d", i), 64'(m_valid[i]), 64'd0);
    end

    // little-endian split
    endian[0] = 1'b0; s_data[0] = 64'h0706050403020100; s_valid[0] = 1'b1; m_ready[0] = 1'b1;
    #1 chk("le_sready", 64'(s_ready[0]), 64'd1);
    @(negedge s_clk);
    s_valid[0] = 1'b0;
    chk("le_v0", 64'(m_valid[0]), 64'd1);
    chk("le_d0", 64'(m_data0), 64'h03020100);
    chk("le_l0", 64'(m_last[0]), 64'd0);
    @(negedge s_clk);
    chk("le_d1", 64'(m_data0), 64'h07060504);
    chk("le_l1", 64'(m_last[0]), 64'd1);
    @(negedge s_clk);
    chk("le_done", 64'(m_valid[0]), 64'd0);

    // big-endian split, endian toggled after the word is loaded
    endian[0] = 1'b1; s_valid[0] = 1'b1; m_ready[0] = 1'b0;
    @(negedge s_clk);
    s_valid[0] = 1'b0; endian[0] = 1'b0;
    chk("be_v0", 64'(m_valid[0]), 64'd1);
    chk("be_d0", 64'(m_data0), 64'h07060504);
    chk("be_l0", 64'(m_last[0]), 64'd0);
    m_ready[0] = 1'b1;
    @(negedge s_clk);
    chk("be_d1", 64'(m_data0), 64'h03020100);
    chk("be_l1", 64'(m_last[0]), 64'd1);
    @(negedge s_clk);
    chk("be_done", 64'(m_valid[0]), 64'd0);

    // reset after the first beat discards the rest of the word
    s_data[0] = 64'h1111111122222222; s_valid[0] = 1'b1;
    @(negedge s_clk);
    s_valid[0] = 1'b0;
    chk("mr_d0", 64'(m_data0), 64'h22222222);
    @(negedge s_clk);
    chk("mr_d1_pending", 64'(m_data0), 64'h11111111);
    reset = 1'b1; m_ready[0] = 1'b0;
    @(negedge s_clk);
    chk("mr_rst_v", 64'(m_valid[0]), 64'd0);
    chk("mr_rst_l", 64'(m_last[0]), 64'd0);
    reset = 1'b0;
    @(negedge s_clk);
    chk("mr_no_stale", 64'(m_valid[0]), 64'd0);
    s_data[0] = 64'hAAAAAAAABBBBBBBB; s_valid[0] = 1'b1; m_ready[0] = 1'b1;
    @(negedge s_clk);
    s_valid[0] = 1'b0;
    chk("mr_fresh_d0", 64'(m_data0), 64'hBBBBBBBB);
    chk("mr_fresh_l0", 64'(m_last[0]), 64'd0);
    @(negedge s_clk);
    chk("mr_fresh_d1", 64'(m_data0), 64'hAAAAAAAA);
    chk("mr_fresh_l1", 64'(m_last[0]), 64'd1);
    @(negedge s_clk);
    m_ready[0] = 1'b0;

    // continuous throughput: 8 words -> 16 beats in 16 consecutive cycles
    do_reset();
    for (int i = 0; i < 2; i++) begin
      vp[i] = 100; rp[i] = 100; left[i] = 8;
    end
    repeat (40) step();
    chk("tp_first0", 64'(first_beat[0]), 64'd1);
    chk("tp_first1", 64'(first_beat[1]), 64'd2);
    chk("tp_nbeats0", 64'(nbeats[0]), 64'd16);
    chk("tp_nbeats1", 64'(nbeats[1]), 64'd16);
    chk("tp_span0", 64'(last_cyc[0] - first_beat[0]), 64'd15);
    chk("tp_span1", 64'(last_cyc[1] - first_beat[1]), 64'd15);

    // random valid/ready traffic on all ratios
    do_reset();
    for (int i = 0; i < NI; i++) begin
      vp[i] = 40 + 15 * i; rp[i] = 75 - 10 * i; left[i] = 1500;
    end
    while (outstanding() != 0 && cyc < 60000) step();
    chk("rand_drained", 64'(outstanding()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
